// File: rtl/demux_1to4_tdm.sv
// 1-to-4 TDM demultiplexer: hunts for the frame marker, then deals serial
// bits into four channel registers that refresh together once per frame.
//
// state  | meaning
// HUNT   | waiting for a Sync-qualified sample to mark slot A
// LOCKED | framing acquired; slot counter tracks A,B,C,D
module demux_1to4_tdm #(
   parameter bit SYNC_STRICT = 1'b0
) (
   input  logic CLK,
   input  logic RST,
   input  logic Mux_in,
   input  logic Sync,
   input  logic Enable,
   output logic A_out,
   output logic B_out,
   output logic C_out,
   output logic D_out,
   output logic S1,
   output logic S0,
   output logic Frame_valid,
   output logic Locked,
   output logic Sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [1:0] slot, slot_nxt;
   // shadow[2] = A, shadow[1] = B, shadow[0] = C; D never needs storing
   logic [2:0] shadow, shadow_nxt;
   logic [3:0] frame, frame_nxt;
   logic       frame_valid_nxt;
   logic       sync_err_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= HUNT;
         slot        <= 2'd0;
         shadow      <= 3'd0;
         frame       <= 4'd0;
         Frame_valid <= 1'b0;
         Sync_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         slot        <= slot_nxt;
         shadow      <= shadow_nxt;
         frame       <= frame_nxt;
         Frame_valid <= frame_valid_nxt;
         Sync_err    <= sync_err_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      slot_nxt        = slot;
      shadow_nxt      = shadow;
      frame_nxt       = frame;
      frame_valid_nxt = 1'b0;
      sync_err_nxt    = Sync_err;
      if (Enable) begin
         case (state)
            HUNT: begin
               if (Sync) begin
                  shadow_nxt[2] = Mux_in;
                  slot_nxt      = 2'd1;
                  state_nxt     = LOCKED;
               end
            end
            LOCKED: begin
               if (Sync && (slot != 2'd0)) begin
                  // early marker: drop the partial frame and restart at B
                  sync_err_nxt  = 1'b1;
                  shadow_nxt[2] = Mux_in;
                  slot_nxt      = 2'd1;
               end else if (!Sync && (slot == 2'd0) && SYNC_STRICT) begin
                  sync_err_nxt = 1'b1;
                  slot_nxt     = 2'd0;
                  state_nxt    = HUNT;
               end else begin
                  case (slot)
                     2'd0: shadow_nxt[2] = Mux_in;
                     2'd1: shadow_nxt[1] = Mux_in;
                     2'd2: shadow_nxt[0] = Mux_in;
                     default: begin
                        frame_nxt       = {shadow, Mux_in};
                        frame_valid_nxt = 1'b1;
                     end
                  endcase
                  slot_nxt = slot + 2'd1;
               end
            end
            default: begin
               state_nxt = HUNT;
               slot_nxt  = 2'd0;
            end
         endcase
      end
   end

   assign {A_out, B_out, C_out, D_out} = frame;
   assign {S1, S0}                     = slot;
   assign Locked                       = (state == LOCKED);

endmodule
